// File: rtl/param_updown_counter.sv
// param_updown_counter
//   Parametrised synchronous up/down counter. It has a clock-enable prescaler, parallel load
//   with clamping, wrap or saturate behaviour at the range ends, a one-cycle terminal-count
//   pulse and a sticky overflow/underflow flag.
//
// Parameters
//   WIDTH    : counter width in bits (1..31).
//   MAX_VAL  : top of the count range; q spans 0..MAX_VAL (1..2**WIDTH-1).
//   PRESCALE : one step per PRESCALE enabled cycles (>= 1).
//   SATURATE : 0 = wrap at the range ends, 1 = hold at the range ends.
//
// Ports
//   clk_i      : rising-edge clock.
//   rst_i      : synchronous active-high reset. It overrides every other input.
//   en_i       : count enable. It gates both the prescaler and the step.
//   up_i       : direction, 1 = increment, 0 = decrement. Only used on step cycles.
//   load_i     : parallel load strobe. It has priority over counting.
//   load_val_i : load value. Values above MAX_VAL load as MAX_VAL.
//   clr_ovf_i  : clears the sticky overflow flag. A boundary step on the same edge wins.
//   q_o        : current count (registered).
//   tc_o       : terminal-count pulse (registered). It is high after each boundary step.
//   ovf_o      : sticky overflow/underflow flag (registered).
module param_updown_counter #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MAX_VAL  = 2**WIDTH - 1,
  parameter int unsigned PRESCALE = 1,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             up_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             clr_ovf_i,
  output logic [WIDTH-1:0] q_o,
  output logic             tc_o,
  output logic             ovf_o
);

  // Elaboration-time parameter checks
  if (WIDTH < 1 || WIDTH > 31) begin : gen_bad_width
    $error("param_updown_counter: WIDTH must be in 1..31");
  end
  if (MAX_VAL < 1 || MAX_VAL > (2**WIDTH - 1)) begin : gen_bad_max
    $error("param_updown_counter: MAX_VAL must be in 1..2**WIDTH-1");
  end
  if (PRESCALE < 1) begin : gen_bad_prescale
    $error("param_updown_counter: PRESCALE must be >= 1");
  end

  // Arithmetic uses one extra bit so that comparisons against MAX_VAL and the load clamp
  // do not alias.
  localparam int unsigned    WExt    = WIDTH + 1;
  localparam logic [WIDTH:0] MaxExt  = WExt'(MAX_VAL);
  localparam logic [WIDTH:0] ZeroExt = '0;
  localparam logic [WIDTH:0] OneExt  = WExt'(1);

  // Prescaler phase counter. It is 1 bit wide even when PRESCALE=1, where it stays at 0.
  localparam int unsigned     PscW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PscW-1:0] PscLast = PscW'(PRESCALE - 1);
  localparam logic [PscW-1:0] PscOne  = PscW'(1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic [PscW-1:0]  psc_q, psc_d;

  logic [WIDTH:0] q_ext, load_ext, clamp_ext, inc_ext, dec_ext;
  logic           psc_last;
  logic           step;
  logic           at_top, at_bot;
  logic           boundary;
  logic           unused_msbs;

  assign q_ext     = {1'b0, q_q};
  assign load_ext  = {1'b0, load_val_i};
  assign clamp_ext = (load_ext > MaxExt) ? MaxExt : load_ext;
  assign inc_ext   = q_ext + OneExt;
  // This wraps to all-ones when q is 0. It is never selected in that case because the
  // boundary path handles q == 0.
  assign dec_ext   = q_ext - OneExt;

  // Bit WIDTH of each of these is 0 whenever it is selected, so only the low bits are kept.
  assign unused_msbs = ^{clamp_ext[WIDTH], inc_ext[WIDTH], dec_ext[WIDTH]};

  assign psc_last = (psc_q == PscLast);
  assign step     = en_i & ~load_i & psc_last;
  assign at_top   = (q_ext == MaxExt);
  assign at_bot   = (q_ext == ZeroExt);
  assign boundary = step & (up_i ? at_top : at_bot);

  always_comb begin
    q_d   = q_q;
    psc_d = psc_q;
    tc_d  = 1'b0;
    ovf_d = ovf_q & ~clr_ovf_i;

    if (load_i) begin
      q_d   = clamp_ext[WIDTH-1:0];
      psc_d = '0;
    end else if (en_i) begin
      psc_d = psc_last ? '0 : (psc_q + PscOne);
      if (step) begin
        if (boundary) begin
          tc_d  = 1'b1;
          // The set has priority over clr_ovf_i on the same edge.
          ovf_d = 1'b1;
          if (!SATURATE) begin
            q_d = up_i ? ZeroExt[WIDTH-1:0] : MaxExt[WIDTH-1:0];
          end
        end else begin
          q_d = up_i ? inc_ext[WIDTH-1:0] : dec_ext[WIDTH-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q   <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
      psc_q <= '0;
    end else begin
      q_q   <= q_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
      psc_q <= psc_d;
    end
  end

  assign q_o   = q_q;
  assign tc_o  = tc_q;
  assign ovf_o = ovf_q;

endmodule

// File: tb/tb_param_updown_counter.sv
// Bench for param_updown_counter. Four instances share one stimulus stream:
//   0: WIDTH=4 MAX=15 PRESCALE=1 wrap
//   1: WIDTH=4 MAX=9  PRESCALE=1 wrap
//   2: WIDTH=4 MAX=9  PRESCALE=1 saturate
//   3: WIDTH=4 MAX=9  PRESCALE=3 wrap
// An integer-arithmetic model of every instance is compared on each falling edge.
// Directed scenarios also check hand-computed literal values.
module tb_param_updown_counter;

  logic       clk;
  logic       rst, en, up, load, clr;
  logic [3:0] load_val;

  logic [3:0] dq   [4];
  logic       dtc  [4];
  logic       dovf [4];

  int n_checks = 0;
  int n_pass   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  param_updown_counter #(.WIDTH(4), .MAX_VAL(15), .PRESCALE(1), .SATURATE(1'b0)) u_def (
    .clk_i(clk), .rst_i(rst), .en_i(en), .up_i(up), .load_i(load), .load_val_i(load_val),
    .clr_ovf_i(clr), .q_o(dq[0]), .tc_o(dtc[0]), .ovf_o(dovf[0])
  );
  param_updown_counter #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(1), .SATURATE(1'b0)) u_dec (
    .clk_i(clk), .rst_i(rst), .en_i(en), .up_i(up), .load_i(load), .load_val_i(load_val),
    .clr_ovf_i(clr), .q_o(dq[1]), .tc_o(dtc[1]), .ovf_o(dovf[1])
  );
  param_updown_counter #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(1), .SATURATE(1'b1)) u_sat (
    .clk_i(clk), .rst_i(rst), .en_i(en), .up_i(up), .load_i(load), .load_val_i(load_val),
    .clr_ovf_i(clr), .q_o(dq[2]), .tc_o(dtc[2]), .ovf_o(dovf[2])
  );
  param_updown_counter #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(3), .SATURATE(1'b0)) u_psc (
    .clk_i(clk), .rst_i(rst), .en_i(en), .up_i(up), .load_i(load), .load_val_i(load_val),
    .clr_ovf_i(clr), .q_o(dq[3]), .tc_o(dtc[3]), .ovf_o(dovf[3])
  );

  // Model parameters and state
  int cmax [4] = '{15, 9, 9, 9};
  int cpre [4] = '{1, 1, 1, 3};
  bit csat [4] = '{0, 0, 1, 0};

  int mq   [4];
  int mpsc [4];
  bit mtc  [4];
  bit movf [4];
  bit started = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Model: enabled cycles are counted, and every PRESCALE-th one moves the count by +/-1.
  // A result outside 0..MAX either wraps modulo MAX+1 or stays put, and raises tc/ovf.
  always @(posedge clk) begin
    int nq, np, tgt;
    bit ntc, novf;
    for (int i = 0; i < 4; i++) begin
      nq   = mq[i];
      np   = mpsc[i];
      ntc  = 1'b0;
      novf = movf[i] & ~clr;
      if (rst) begin
        nq = 0; np = 0; novf = 1'b0;
      end else if (load) begin
        nq = (int'(load_val) > cmax[i]) ? cmax[i] : int'(load_val);
        np = 0;
      end else if (en) begin
        np = np + 1;
        if (np == cpre[i]) begin
          np  = 0;
          tgt = up ? nq + 1 : nq - 1;
          if (tgt < 0 || tgt > cmax[i]) begin
            ntc  = 1'b1;
            novf = 1'b1;
            tgt  = csat[i] ? nq : (tgt + cmax[i] + 1) % (cmax[i] + 1);
          end
          nq = tgt;
        end
      end
      mq[i]   <= nq;
      mpsc[i] <= np;
      mtc[i]  <= ntc;
      movf[i] <= novf;
    end
    if (rst) started <= 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("model q[%0d]", i), 32'(dq[i]), 32'(mq[i]));
        chk($sformatf("model tc[%0d]", i), 32'(dtc[i]), 32'(mtc[i]));
        chk($sformatf("model ovf[%0d]", i), 32'(dovf[i]), 32'(movf[i]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int dec_exp [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
  int psc_exp [11] = '{0, 0, 1, 1, 1, 2, 2, 2, 2, 2, 3};

  initial begin
    rst = 1'b1; en = 1'b1; up = 1'b1; load = 1'b0; clr = 1'b0; load_val = '0;

    // Reset, then count up
    tick(); tick();
    chk("reset q", 32'(dq[0]), 0);
    chk("reset tc", 32'(dtc[0]), 0);
    chk("reset ovf", 32'(dovf[0]), 0);
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("post-reset q%0d", i), 32'(dq[0]), 32'(i));
    end

    // Decade wrap
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk($sformatf("decade q step%0d", i), 32'(dq[1]), 32'(dec_exp[i]));
      chk($sformatf("decade tc step%0d", i), 32'(dtc[1]), (i == 9) ? 1 : 0);
      chk($sformatf("decade ovf step%0d", i), 32'(dovf[1]), (i >= 9) ? 1 : 0);
    end
    clr = 1'b1; tick(); clr = 1'b0;
    chk("decade clr ovf", 32'(dovf[1]), 0);

    // Underflow in saturate mode
    load = 1'b1; load_val = 4'd1; tick(); load = 1'b0;
    chk("sat load 1", 32'(dq[2]), 1);
    up = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("sat down q%0d", i), 32'(dq[2]), 0);
      chk($sformatf("sat down tc%0d", i), 32'(dtc[2]), (i >= 1) ? 1 : 0);
    end
    chk("sat down ovf", 32'(dovf[2]), 1);
    up = 1'b1; tick();
    chk("sat up from 0", 32'(dq[2]), 1);
    chk("sat up tc", 32'(dtc[2]), 0);

    // Load clamp, then a load that collides with a boundary step
    load = 1'b1; load_val = 4'd14; tick();
    chk("clamp dec", 32'(dq[1]), 9);
    chk("clamp sat", 32'(dq[2]), 9);
    chk("no clamp def", 32'(dq[0]), 14);
    load_val = 4'd3; tick(); load = 1'b0;
    chk("load beats step q", 32'(dq[1]), 3);
    chk("load beats step tc", 32'(dtc[1]), 0);

    // Prescaler with en dropped for two cycles mid-phase
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 11; i++) begin
      en = !(i == 7 || i == 8);
      tick();
      chk($sformatf("prescale q%0d", i), 32'(dq[3]), 32'(psc_exp[i]));
    end
    en = 1'b1;

    // Reset in the middle of a count
    load = 1'b1; load_val = 4'd9; tick(); load = 1'b0;
    tick();
    chk("wrap sets ovf", 32'(dovf[1]), 1);
    load = 1'b1; load_val = 4'd5; tick(); load = 1'b0;
    chk("load 5 q", 32'(dq[1]), 5);
    chk("load keeps ovf", 32'(dovf[1]), 1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("midreset q", 32'(dq[1]), 0);
    chk("midreset ovf", 32'(dovf[1]), 0);
    chk("midreset tc", 32'(dtc[1]), 0);

    // Saturate at the top
    load = 1'b1; load_val = 4'd15; tick(); load = 1'b0;
    chk("sat load top", 32'(dq[2]), 9);
    tick();
    chk("sat top hold q", 32'(dq[2]), 9);
    chk("sat top tc", 32'(dtc[2]), 1);
    chk("sat top ovf", 32'(dovf[2]), 1);

    // clr_ovf on the same edge as a wrap: the set wins
    load = 1'b1; load_val = 4'd9; tick(); load = 1'b0;
    clr = 1'b1; tick();
    chk("race q", 32'(dq[1]), 0);
    chk("race tc", 32'(dtc[1]), 1);
    chk("race ovf", 32'(dovf[1]), 1);
    tick(); clr = 1'b0;
    chk("clr after race", 32'(dovf[1]), 0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/param_updown_counter.md
# param_updown_counter

Parametrised synchronous up/down counter: the next generation of the team's 4-bit up counter. It adds configurable width and modulus, direction control, parallel load, count enable, a clock-enable prescaler, wrap or saturate mode, a terminal-count pulse and a sticky overflow flag. It is a general-purpose timing and event-counting primitive for use in timers, dividers and sequencers.

## Interface
Parameters:
- WIDTH, 4: counter width in bits, ≥1.
- MAX_VAL, 2**WIDTH-1: top of count range; q spans 0..MAX_VAL; must satisfy 1 ≤ MAX_VAL ≤ 2**WIDTH-1.
- PRESCALE, 1: count steps once per PRESCALE enabled cycles, ≥1.
- SATURATE, 0: 0 = wrap at range ends, 1 = hold at range ends.

Ports:
- clk  in  1  rising-edge clock, sole clock domain.
- rst  in  1  synchronous, active-high reset.
- en  in  1  count enable; gates the prescaler and the step.
- up  in  1  direction: 1 = increment, 0 = decrement; sampled on step cycles only.
- load  in  1  parallel load strobe.
- load_val  in  WIDTH  value to load; values > MAX_VAL are clamped to MAX_VAL.
- clr_ovf  in  1  clears the sticky ovf flag.
- q  out  WIDTH  current count, registered.
- tc  out  1  terminal-count pulse, registered, one cycle wide.
- ovf  out  1  sticky overflow/underflow flag, registered.

## Operation
- Reset (rst=1 at a clk edge): q=0, tc=0, ovf=0, prescaler=0. Reset overrides all other inputs.
- Priority per edge: rst > load > step > hold.
- Load (load=1): q ← min(load_val, MAX_VAL), prescaler ← 0, tc ← 0. Load takes effect regardless of en. ovf is unchanged except for clr_ovf.
- Prescaler: an internal counter runs 0..PRESCALE-1 and advances only when en=1 and load=0. A step occurs on the edge where en=1 and the prescaler equals PRESCALE-1; the prescaler returns to 0 on that edge. With PRESCALE=1, every enabled cycle is a step. When en=0, the prescaler and q hold.
- Step, up=1:
  - q<MAX_VAL: q ← q+1.
  - q==MAX_VAL: wrap mode q ← 0; saturate mode q holds at MAX_VAL. In both modes tc ← 1 and ovf ← 1.
- Step, up=0:
  - q>0: q ← q−1.
  - q==0: wrap mode q ← MAX_VAL; saturate mode q holds at 0. In both modes tc ← 1 and ovf ← 1.
- Saturate mode: tc and ovf re-assert on every further step attempted at the boundary.
- tc is 0 on every edge that is not a boundary step.
- ovf is cleared by clr_ovf=1. If a boundary step and clr_ovf occur on the same edge, the set wins and ovf stays 1.
- Arithmetic is done at WIDTH+1 bits internally. q never leaves 0..MAX_VAL, including under load clamping.
- Direction may change on any cycle. A change between steps does not disturb the prescaler phase.

## Timing
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Latency: an input sampled at edge N is reflected on q/tc/ovf after edge N.
- tc rises on the same edge q takes its wrapped or held value, and falls on the next edge unless that edge is also a boundary step.
- First step after reset or load: PRESCALE enabled cycles later.
- Reset mid-count: the next edge gives q=0, tc=0, ovf=0, with the prescaler phase discarded. Counting resumes PRESCALE enabled cycles after rst falls.
- Load on the same cycle as a would-be step: load wins, no step, no tc.

## Test plan
- Reset: rst=1 for 2 cycles with en=1, up=1 → q=0, tc=0, ovf=0; after rst falls, q reads 1, 2, 3 on successive edges (WIDTH=4, PRESCALE=1).
- Decade wrap: WIDTH=4, MAX_VAL=9, SATURATE=0, en=1, up=1 for 12 cycles → q sequence 1..9, 0, 1, 2; tc=1 only on the edge q becomes 0; ovf=1 from then on. Pulse clr_ovf → ovf=0.
- Underflow and saturate: SATURATE=1, MAX_VAL=9, load 1, then up=0 for 3 steps → q=0, 0, 0 with tc=1 on the 2nd and 3rd steps. Then up=1 → q=1.
- Load and clamp: load=1 with load_val=14 and MAX_VAL=9 → q=9. Load during an active step with load_val=3 → q=3, tc=0.
- Prescaler: PRESCALE=3, en=1 → q increments every 3rd edge. Drop en for 2 cycles mid-phase → the step is delayed by exactly 2 cycles.
- Mid-operation reset and flag race: q=5 and ovf=1, assert rst for one edge → q=0, ovf=0. Separately, apply clr_ovf on the same edge as a wrap → ovf stays 1.
